cordic_rotacao_quadrante: RTL and testbench

CORDIC_ROTACAO_QUADRANTE -- requirements
Module: cordic_rotacao_quadrante

---
 rtl/cordic_rotacao_quadrante.sv | 157 +++++++++++++++
 tb/tb_cordic_rotacao_quadrante.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotacao_quadrante.sv
// Rotation-mode CORDIC producing cos/sin of a reduced angle, followed by a
// quadrant correction that maps the result back onto the original angle.
module cordic_rotacao_quadrante #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] z_in,
    input  logic [2:0]              quadrante,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IW = 5;
    localparam logic signed [WIDTH-1:0] K_INIT = WIDTH'(39797);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERA   = 2'd1,
        CORRIGE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic [IW-1:0]           i_q, i_d;
    logic [2:0]              quad_q, quad_d;
    logic signed [WIDTH-1:0] cos_d, sin_d;
    logic                    done_d, busy_d;
    logic signed [WIDTH-1:0] x_sh, y_sh, atan_i;

    // arctan(2^-i) in Q16.16
    function automatic logic signed [WIDTH-1:0] atan_lut(input logic [IW-1:0] idx);
        case (idx)
            5'd0:    atan_lut = WIDTH'(51472);
            5'd1:    atan_lut = WIDTH'(30386);
            5'd2:    atan_lut = WIDTH'(16055);
            5'd3:    atan_lut = WIDTH'(8150);
            5'd4:    atan_lut = WIDTH'(4091);
            5'd5:    atan_lut = WIDTH'(2047);
            5'd6:    atan_lut = WIDTH'(1024);
            5'd7:    atan_lut = WIDTH'(512);
            5'd8:    atan_lut = WIDTH'(256);
            5'd9:    atan_lut = WIDTH'(128);
            5'd10:   atan_lut = WIDTH'(64);
            5'd11:   atan_lut = WIDTH'(32);
            5'd12:   atan_lut = WIDTH'(16);
            5'd13:   atan_lut = WIDTH'(8);
            5'd14:   atan_lut = WIDTH'(4);
            5'd15:   atan_lut = WIDTH'(2);
            default: atan_lut = '0;
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            quad_q  <= '0;
            cos_out <= '0;
            sin_out <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            quad_q  <= quad_d;
            cos_out <= cos_d;
            sin_out <= sin_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

    // Next-state, iteration datapath and quadrant correction
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        quad_d  = quad_q;
        cos_d   = cos_out;
        sin_d   = sin_out;
        done_d  = 1'b0;
        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;
        atan_i  = atan_lut(i_q);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    x_d     = K_INIT;
                    y_d     = '0;
                    z_d     = z_in;
                    quad_d  = quadrante;
                    i_d     = '0;
                    state_d = ITERA;
                end
            end
            ITERA: begin
                if (!z_q[WIDTH-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                i_d = i_q + IW'(1);
                if (i_q == IW'(ITER - 1)) begin
                    state_d = CORRIGE;
                end
            end
            CORRIGE: begin
                case (quad_q)
                    3'd1: begin
                        cos_d = -y_q;
                        sin_d = x_q;
                    end
                    3'd2, 3'd3: begin
                        cos_d = -x_q;
                        sin_d = -y_q;
                    end
                    3'd4: begin
                        cos_d = y_q;
                        sin_d = -x_q;
                    end
                    default: begin
                        cos_d = x_q;
                        sin_d = y_q;
                    end
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // busy also covers the done cycle so the handshake never shows a gap
        busy_d = (state_d != IDLE) || done_d;
    end

endmodule

// File: tb/tb_cordic_rotacao_quadrante.sv
// Scoreboard bench for cordic_rotacao_quadrante: bit-exact CORDIC model plus
// tolerance checks against ideal trig values, timing and reset scenarios.
module tb_cordic_rotacao_quadrante;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 16;
    localparam int LAT = 17;
    localparam int TOL = 16;

    logic                    clk;
    logic                    rst;
    logic                    enable;
    logic signed [WIDTH-1:0] z_in;
    logic [2:0]              quadrante;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;
    logic                    busy;
    logic                    done;

    typedef struct {
        int c;
        int s;
        int cap;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   atan_t[16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                         256, 128, 64, 32, 16, 8, 4, 2};

    cordic_rotacao_quadrante #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .z_in      (z_in),
        .quadrante (quadrante),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic void model(input int z0, input logic [2:0] q, output int c, output int s);
        int x, y, z, xn;
        x = 39797;
        y = 0;
        z = z0;
        for (int i = 0; i < 16; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atan_t[i];
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atan_t[i];
            end
            x = xn;
        end
        case (q)
            3'd1:       begin c = -y; s = x;  end
            3'd2, 3'd3: begin c = -x; s = -y; end
            3'd4:       begin c = y;  s = -x; end
            default:    begin c = x;  s = y;  end
        endcase
    endfunction

    // Called at a falling edge; capture happens on the following rising edge
    task automatic drive_start(input int z, input logic [2:0] q);
        exp_t e;
        int c, s;
        model(z, q, c, s);
        e.c = c;
        e.s = s;
        e.cap = cyc + 1;
        exp_q.push_back(e);
        enable    = 1'b1;
        z_in      = z;
        quadrante = q;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int busy_lows);
        seen = 1'b0;
        busy_lows = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_lows++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b0;
        z_in = '0;
        quadrante = '0;
        repeat (2) @(negedge clk);
        checks++; if (cos_out !== 0) begin failures++; $display("FAIL reset_cos: got %0d want 0", cos_out); end
        checks++; if (sin_out !== 0) begin failures++; $display("FAIL reset_sin: got %0d want 0", sin_out); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b1;
    endtask

    task automatic test_zero_angle();
        bit seen;
        int bl, cv, sv, hold_c;
        exp_t e;
        drive_start(0, 3'd0);
        wait_done(40, seen, bl);
        checks++; if (!seen) begin failures++; $display("FAIL zero_timeout: done not seen, want pulse"); end
        if (seen) begin
            e = exp_q.pop_front();
            cv = cos_out;
            sv = sin_out;
            checks++; if (cyc - e.cap != LAT) begin failures++; $display("FAIL zero_latency: got %0d want %0d", cyc - e.cap, LAT); end
            checks++; if (cv != e.c || sv != e.s) begin failures++; $display("FAIL zero_exact: got %0d/%0d want %0d/%0d", cv, sv, e.c, e.s); end
            checks++; if (cv - 65536 > TOL || 65536 - cv > TOL || sv > TOL || -sv > TOL) begin
                failures++; $display("FAIL zero_ideal: got %0d/%0d want 65536/0 +-16", cv, sv); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_done: got %b want 1", busy); end
            checks++; if (bl != 0) begin failures++; $display("FAIL zero_busy_run: busy low %0d cycles want 0", bl); end
            hold_c = cv;
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_after: done=%b busy=%b want 0/0", done, busy); end
            checks++; if (cos_out !== hold_c) begin failures++; $display("FAIL zero_hold: got %0d want %0d", cos_out, hold_c); end
        end else exp_q.delete();
    endtask

    task automatic test_quadrants();
        int ic[8] = '{65536, 0, -65536, -65536, 0, 65536, 65536, 65536};
        int is[8] = '{0, 65536, 0, 0, -65536, 0, 0, 0};
        bit seen;
        int bl, cv, sv;
        exp_t e;
        for (int q = 0; q < 8; q++) begin
            drive_start(0, 3'(q));
            wait_done(40, seen, bl);
            checks++; if (!seen) begin failures++; $display("FAIL quad%0d_timeout: done not seen, want pulse", q); end
            if (seen) begin
                e = exp_q.pop_front();
                cv = cos_out;
                sv = sin_out;
                checks++; if (cv != e.c || sv != e.s) begin failures++; $display("FAIL quad%0d_exact: got %0d/%0d want %0d/%0d", q, cv, sv, e.c, e.s); end
                checks++; if (cv - ic[q] > TOL || ic[q] - cv > TOL || sv - is[q] > TOL || is[q] - sv > TOL) begin
                    failures++; $display("FAIL quad%0d_ideal: got %0d/%0d want %0d/%0d +-16", q, cv, sv, ic[q], is[q]); end
            end else exp_q.delete();
            @(negedge clk);
        end
    endtask

    task automatic test_pi4();
        int zs[2] = '{51472, -51472};
        int ss[2] = '{46341, -46341};
        bit seen;
        int bl, cv, sv;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive_start(zs[k], 3'd0);
            wait_done(40, seen, bl);
            checks++; if (!seen) begin failures++; $display("FAIL pi4_%0d_timeout: done not seen, want pulse", k); end
            if (seen) begin
                e = exp_q.pop_front();
                cv = cos_out;
                sv = sin_out;
                checks++; if (cv != e.c || sv != e.s) begin failures++; $display("FAIL pi4_%0d_exact: got %0d/%0d want %0d/%0d", k, cv, sv, e.c, e.s); end
                checks++; if (cv - 46341 > TOL || 46341 - cv > TOL || sv - ss[k] > TOL || ss[k] - sv > TOL) begin
                    failures++; $display("FAIL pi4_%0d_ideal: got %0d/%0d want 46341/%0d +-16", k, cv, sv, ss[k]); end
            end else exp_q.delete();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        bit seen;
        int bl, z;
        logic [2:0] q;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            z = int'($urandom_range(102944)) - 51472;
            q = 3'($urandom_range(7));
            drive_start(z, q);
            wait_done(40, seen, bl);
            checks++; if (!seen) begin failures++; $display("FAIL rand%0d_timeout: done not seen, want pulse", k); end
            if (seen) begin
                e = exp_q.pop_front();
                checks++; if (cos_out !== e.c || sin_out !== e.s) begin
                    failures++; $display("FAIL rand%0d_exact z=%0d q=%0d: got %0d/%0d want %0d/%0d", k, z, q, cos_out, sin_out, e.c, e.s); end
            end else exp_q.delete();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int bl, cnt0;
        exp_t e;
        drive_start(51472, 3'd1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_flags: busy=%b done=%b want 0/0", busy, done); end
        checks++; if (cos_out !== 0 || sin_out !== 0) begin failures++; $display("FAIL rstmid_out: got %0d/%0d want 0/0", cos_out, sin_out); end
        exp_q.delete();
        cnt0 = done_cnt;
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != cnt0) begin failures++; $display("FAIL rstmid_nodone: got %0d pulses want 0", done_cnt - cnt0); end
        rst = 1'b1;
        drive_start(0, 3'd0);
        wait_done(40, seen, bl);
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_timeout: done not seen, want pulse"); end
        if (seen) begin
            e = exp_q.pop_front();
            checks++; if (cyc - e.cap != LAT) begin failures++; $display("FAIL rstmid_latency: got %0d want %0d", cyc - e.cap, LAT); end
            checks++; if (cos_out !== e.c || sin_out !== e.s) begin failures++; $display("FAIL rstmid_exact: got %0d/%0d want %0d/%0d", cos_out, sin_out, e.c, e.s); end
        end else exp_q.delete();
        repeat (25) @(negedge clk);
        checks++; if (done_cnt != cnt0 + 1) begin failures++; $display("FAIL rstmid_count: got %0d pulses want 1", done_cnt - cnt0); end
    endtask

    task automatic test_enable_busy();
        bit seen;
        int bl, cnt0;
        exp_t e;
        cnt0 = done_cnt;
        drive_start(0, 3'd0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        z_in = 51472;
        @(negedge clk);
        enable = 1'b0;
        wait_done(40, seen, bl);
        checks++; if (!seen) begin failures++; $display("FAIL busyen_timeout: done not seen, want pulse"); end
        if (seen) begin
            e = exp_q.pop_front();
            checks++; if (cyc - e.cap != LAT) begin failures++; $display("FAIL busyen_latency: got %0d want %0d", cyc - e.cap, LAT); end
            checks++; if (cos_out !== e.c || sin_out !== e.s) begin failures++; $display("FAIL busyen_exact: got %0d/%0d want %0d/%0d", cos_out, sin_out, e.c, e.s); end
        end else exp_q.delete();
        repeat (25) @(negedge clk);
        checks++; if (done_cnt != cnt0 + 1) begin failures++; $display("FAIL busyen_count: got %0d pulses want 1", done_cnt - cnt0); end
    endtask

    task automatic test_back_to_back();
        bit seen1, seen2;
        int bl, t1, c, s;
        exp_t ea, eb;
        model(30000, 3'd1, c, s);
        ea.c = c; ea.s = s; ea.cap = cyc + 1;
        exp_q.push_back(ea);
        enable = 1'b1;
        z_in = 30000;
        quadrante = 3'd1;
        wait_done(40, seen1, bl);
        t1 = cyc;
        checks++; if (!seen1) begin failures++; $display("FAIL b2b_first_timeout: done not seen, want pulse"); end
        if (seen1) begin
            ea = exp_q.pop_front();
            checks++; if (cos_out !== ea.c || sin_out !== ea.s) begin failures++; $display("FAIL b2b_first_exact: got %0d/%0d want %0d/%0d", cos_out, sin_out, ea.c, ea.s); end
            checks++; if (cyc - ea.cap != LAT) begin failures++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc - ea.cap, LAT); end
        end
        model(-20000, 3'd4, c, s);
        eb.c = c; eb.s = s; eb.cap = cyc + 1;
        exp_q.push_back(eb);
        z_in = -20000;
        quadrante = 3'd4;
        wait_done(40, seen2, bl);
        enable = 1'b0;
        checks++; if (!seen2) begin failures++; $display("FAIL b2b_second_timeout: done not seen, want pulse"); end
        if (seen1 && seen2) begin
            eb = exp_q.pop_front();
            checks++; if (cyc - t1 != 18) begin failures++; $display("FAIL b2b_period: got %0d want 18", cyc - t1); end
            checks++; if (cos_out !== eb.c || sin_out !== eb.s) begin failures++; $display("FAIL b2b_second_exact: got %0d/%0d want %0d/%0d", cos_out, sin_out, eb.c, eb.s); end
        end
        exp_q.delete();
        repeat (25) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_angle();
        test_quadrants();
        test_pi4();
        test_random();
        test_reset_mid();
        test_enable_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
